// File: rtl/frame_pkg.sv
// Shared definitions for the telemetry frame scheduler: FSM encoding, frame
// byte positions, default header values and the 7-bit data mask.
package frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP
   } state_t;

   localparam logic [2:0] IDX_HDR  = 3'd0;
   localparam logic [2:0] IDX_ADC  = 3'd1;
   localparam logic [2:0] IDX_SEC  = 3'd2;
   localparam logic [2:0] IDX_MIN  = 3'd3;
   localparam logic [2:0] IDX_HR   = 3'd4;
   localparam logic [2:0] IDX_DAY  = 3'd5;
   localparam logic [2:0] IDX_MON  = 3'd6;
   localparam logic [2:0] IDX_CSUM = 3'd7;
   localparam int         FRAME_LEN = 8;

   localparam int         GAP_CYCLES_DEF = 16;
   localparam logic [7:0] HDR_NORM_DEF   = 8'hA5;
   localparam logic [7:0] HDR_ALARM_DEF  = 8'h5A;
   localparam logic [7:0] MASK_7BIT      = 8'h7F;

   function automatic logic [7:0] apply_mask(input logic [7:0] b, input logic seven_bit);
      return seven_bit ? (b & MASK_7BIT) : b;
   endfunction

endpackage

// File: rtl/frame_req_arbiter.sv
// Pending-request flags with fixed alarm-over-sample priority and the sticky
// overrun flag for dropped sample requests.
module frame_req_arbiter
   import frame_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_sample_req,
   input  logic i_alarm_req,
   input  logic i_ovr_clr,
   input  logic i_grant_en,
   output logic o_req_any,
   output logic o_grant_alarm,
   output logic o_overrun
);

   logic r_sample_pend;
   logic r_alarm_pend;
   logic r_overrun;

   logic w_sample_eff;
   logic w_alarm_eff;
   logic w_take_alarm;
   logic w_take_sample;
   logic w_ovr_evt;

   // A request in the same cycle counts immediately so IDLE leaves on that edge.
   assign w_sample_eff  = r_sample_pend | i_sample_req;
   assign w_alarm_eff   = r_alarm_pend | i_alarm_req;
   assign w_take_alarm  = i_grant_en & w_alarm_eff;
   assign w_take_sample = i_grant_en & ~w_alarm_eff & w_sample_eff;
   assign w_ovr_evt     = i_sample_req & r_sample_pend & ~w_take_sample;

   assign o_req_any     = w_sample_eff | w_alarm_eff;
   assign o_grant_alarm = w_alarm_eff;
   assign o_overrun     = r_overrun;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample_pend <= 1'b0;
         r_alarm_pend  <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         if (w_take_alarm)
            r_alarm_pend <= 1'b0;
         else
            r_alarm_pend <= w_alarm_eff;

         // When both a stored and a new sample request meet a grant, one survives.
         if (w_take_sample)
            r_sample_pend <= r_sample_pend & i_sample_req;
         else
            r_sample_pend <= w_sample_eff;

         if (w_ovr_evt)
            r_overrun <= 1'b1;
         else if (i_ovr_clr)
            r_overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/telemetry_frame_scheduler.sv
// Builds 8-byte telemetry frames from an ADC/RTC snapshot and streams them to
// the UART serializer; owns the serializer line configuration.
module telemetry_frame_scheduler
   import frame_pkg::*;
#(
   parameter int         GAP_CYCLES = GAP_CYCLES_DEF,
   parameter logic [7:0] HDR_NORM   = HDR_NORM_DEF,
   parameter logic [7:0] HDR_ALARM  = HDR_ALARM_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_req,
   input  logic       alarm_req,
   input  logic [7:0] adc,
   input  logic [5:0] seconds,
   input  logic [5:0] minutes,
   input  logic [4:0] hours,
   input  logic [4:0] days,
   input  logic [3:0] months,
   input  logic [1:0] bd_rate_in,
   input  logic       dnum_in,
   input  logic       snum_in,
   input  logic [1:0] par_in,
   output logic [1:0] bd_rate,
   output logic       dnum,
   output logic       snum,
   output logic [1:0] par,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun,
   input  logic       ovr_clr
);

   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_t          r_state;
   state_t          w_next;
   logic            r_is_alarm;
   logic [7:0]      r_adc;
   logic [5:0]      r_sec;
   logic [5:0]      r_min;
   logic [4:0]      r_hr;
   logic [4:0]      r_day;
   logic [3:0]      r_mon;
   logic [1:0]      r_bd_rate;
   logic            r_dnum;
   logic            r_snum;
   logic [1:0]      r_par;
   logic [2:0]      r_idx;
   logic [GW-1:0]   r_gap_cnt;
   logic [7:0]      r_tx_data;
   logic            r_tx_valid;
   logic            r_frame_done;

   logic            w_req_any;
   logic            w_grant_alarm;
   logic            w_accept;
   logic [2:0]      w_idx_next;
   logic [7:0]      w_csum;
   logic [7:0]      w_next_byte;

   frame_req_arbiter u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_sample_req (sample_req),
      .i_alarm_req  (alarm_req),
      .i_ovr_clr    (ovr_clr),
      .i_grant_en   (r_state == ST_IDLE),
      .o_req_any    (w_req_any),
      .o_grant_alarm(w_grant_alarm),
      .o_overrun    (overrun)
   );

   assign w_accept   = r_tx_valid & tx_ready;
   assign w_idx_next = r_idx + 3'd1;

   // Masking commutes with XOR, so the raw checksum is masked like any other byte.
   assign w_csum = r_adc ^ {2'b00, r_sec} ^ {2'b00, r_min} ^ {3'b000, r_hr}
                 ^ {3'b000, r_day} ^ {4'b0000, r_mon};

   always_comb begin
      w_next_byte = w_csum;
      case (w_idx_next)
         IDX_ADC: w_next_byte = r_adc;
         IDX_SEC: w_next_byte = {2'b00, r_sec};
         IDX_MIN: w_next_byte = {2'b00, r_min};
         IDX_HR:  w_next_byte = {3'b000, r_hr};
         IDX_DAY: w_next_byte = {3'b000, r_day};
         IDX_MON: w_next_byte = {4'b0000, r_mon};
         default: w_next_byte = w_csum;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // NOTE: the default assignment first keeps every path driven, so no latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_req_any) w_next = ST_LOAD;
         ST_LOAD: w_next = ST_SEND;
         ST_SEND: if (w_accept && r_idx == IDX_CSUM) w_next = ST_GAP;
         ST_GAP:  if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_alarm   <= 1'b0;
         r_adc        <= '0;
         r_sec        <= '0;
         r_min        <= '0;
         r_hr         <= '0;
         r_day        <= '0;
         r_mon        <= '0;
         r_bd_rate    <= '0;
         r_dnum       <= 1'b0;
         r_snum       <= 1'b0;
         r_par        <= '0;
         r_idx        <= IDX_HDR;
         r_gap_cnt    <= '0;
         r_tx_data    <= '0;
         r_tx_valid   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_req_any) r_is_alarm <= w_grant_alarm;
            ST_LOAD: begin
               r_adc      <= adc;
               r_sec      <= seconds;
               r_min      <= minutes;
               r_hr       <= hours;
               r_day      <= days;
               r_mon      <= months;
               r_bd_rate  <= bd_rate_in;
               r_dnum     <= dnum_in;
               r_snum     <= snum_in;
               r_par      <= par_in;
               r_idx      <= IDX_HDR;
               r_tx_data  <= apply_mask(r_is_alarm ? HDR_ALARM : HDR_NORM, dnum_in);
               r_tx_valid <= 1'b1;
            end
            ST_SEND: if (w_accept) begin
               if (r_idx == IDX_CSUM) begin
                  r_tx_valid   <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_gap_cnt    <= '0;
               end else begin
                  r_idx     <= w_idx_next;
                  r_tx_data <= apply_mask(w_next_byte, r_dnum);
               end
            end
            ST_GAP:  r_gap_cnt <= r_gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign bd_rate    = r_bd_rate;
   assign dnum       = r_dnum;
   assign snum       = r_snum;
   assign par        = r_par;
   assign tx_data    = r_tx_data;
   assign tx_valid   = r_tx_valid;
   assign frame_done = r_frame_done;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_telemetry_frame_scheduler.sv
// Self-checking bench: expected frames come from a byte-level frame model and
// are compared against the bytes accepted on the tx handshake.
module tb_telemetry_frame_scheduler;

   localparam int G = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_req, alarm_req, ovr_clr;
   logic [7:0] adc;
   logic [5:0] seconds, minutes;
   logic [4:0] hours, days;
   logic [3:0] months;
   logic [1:0] bd_rate_in, par_in;
   logic       dnum_in, snum_in;
   logic [1:0] bd_rate, par;
   logic       dnum, snum;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready, busy, frame_done, overrun;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         n_done  = 0;
   int         ready_mode = 0;
   logic [7:0] acc_q[$];
   logic [7:0] exp_q[$];
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;

   telemetry_frame_scheduler dut (
      .clk(clk), .rst(rst), .sample_req(sample_req), .alarm_req(alarm_req),
      .adc(adc), .seconds(seconds), .minutes(minutes), .hours(hours),
      .days(days), .months(months), .bd_rate_in(bd_rate_in), .dnum_in(dnum_in),
      .snum_in(snum_in), .par_in(par_in), .bd_rate(bd_rate), .dnum(dnum),
      .snum(snum), .par(par), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
      .overrun(overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_tests++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   // Handshake monitor: records accepted bytes and checks hold-stability under stall.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_data", {24'd0, tx_data}, {24'd0, stall_data});
         end
         stall_prev = tx_valid && !tx_ready;
         stall_data = tx_data;
         if (tx_valid && tx_ready) acc_q.push_back(tx_data);
         if (frame_done) n_done++;
      end
   end

   initial begin
      int stall_left = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               if (stall_left > 0) begin
                  tx_ready = 1'b0;
                  stall_left--;
               end else begin
                  tx_ready = 1'b1;
                  stall_left = $urandom_range(0, 5);
               end
            end
            2: tx_ready = 1'b0;
            default: tx_ready = 1'b1;
         endcase
      end
   end

   // Reference frame: header, adc, zero-extended RTC fields, XOR checksum of 1..6.
   function automatic void expect_frame(input bit alarm, input bit seven);
      logic [7:0] b[8];
      logic [7:0] m;
      m = seven ? 8'h7F : 8'hFF;
      b[0] = alarm ? 8'h5A : 8'hA5;
      b[1] = adc;
      b[2] = {2'b00, seconds};
      b[3] = {2'b00, minutes};
      b[4] = {3'b000, hours};
      b[5] = {3'b000, days};
      b[6] = {4'b0000, months};
      b[7] = 8'h00;
      for (int i = 0; i < 7; i++) b[i] = b[i] & m;
      for (int i = 1; i < 7; i++) b[7] = b[7] ^ b[i];
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
   endfunction

   task automatic nclk();
      @(negedge clk);
      #2;
   endtask

   task automatic req(input bit s, input bit a);
      @(posedge clk);
      #1;
      sample_req = s;
      alarm_req  = a;
      @(posedge clk);
      #1;
      sample_req = 1'b0;
      alarm_req  = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 ovr_clr = 1'b1;
      @(posedge clk);
      #1 ovr_clr = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int n = 0;
      do begin
         nclk();
         n++;
      end while (!frame_done && n < max);
      check({tag, "_done_seen"}, {31'd0, frame_done}, 32'd1);
   endtask

   task automatic check_frame(input string tag);
      logic [7:0] g;
      check({tag, "_len"}, acc_q.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         g = (i < acc_q.size()) ? acc_q[i] : 8'hEE;
         check($sformatf("%s_b%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
      end
      acc_q.delete();
   endtask

   task automatic set_fields(input logic [7:0] a, input logic [5:0] s, input logic [5:0] mi,
                             input logic [4:0] h, input logic [4:0] d, input logic [3:0] mo);
      adc = a; seconds = s; minutes = mi; hours = h; days = d; months = mo;
   endtask

   initial begin
      int d0, t_done, n;
      logic [1:0] old_bd;
      bit al;
      rst = 1'b1; sample_req = 1'b0; alarm_req = 1'b0; ovr_clr = 1'b0;
      set_fields(8'h8F, 6'd5, 6'd10, 5'd3, 5'd12, 4'd2);
      bd_rate_in = 2'd0; dnum_in = 1'b0; snum_in = 1'b0; par_in = 2'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      nclk();
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_cfg", {26'd0, bd_rate, dnum, snum, par}, 32'd0);

      // Sample frame, 8-bit mode, with latency and gap checks.
      bd_rate_in = 2'd2; snum_in = 1'b1; par_in = 2'd3;
      expect_frame(1'b0, 1'b0);
      d0 = n_done;
      req(1'b1, 1'b0);
      nclk();
      check("lat_load_valid", {31'd0, tx_valid}, 32'd0);
      check("lat_load_busy", {31'd0, busy}, 32'd1);
      nclk();
      check("lat_hdr_valid", {31'd0, tx_valid}, 32'd1);
      check("lat_hdr_data", {24'd0, tx_data}, 32'hA5);
      wait_done("s8", 40);
      check_frame("s8");
      check("s8_cfg", {26'd0, bd_rate, dnum, snum, par}, {26'd0, 2'd2, 1'b0, 1'b1, 2'd3});
      for (int i = 0; i < G; i++) begin
         check("gap_busy", {31'd0, busy}, 32'd1);
         nclk();
      end
      check("gap_idle", {31'd0, busy}, 32'd0);
      check("s8_done_count", n_done - d0, 32'd1);

      // Same values in 7-bit mode.
      dnum_in = 1'b1;
      expect_frame(1'b0, 1'b1);
      req(1'b1, 1'b0);
      wait_done("s7", 40);
      check_frame("s7");
      check("s7_dnum", {31'd0, dnum}, 32'd1);
      repeat (G + 2) nclk();
      dnum_in = 1'b0;

      // Simultaneous alarm and sample: alarm first, sample LOAD G+1 cycles later.
      expect_frame(1'b1, 1'b0);
      req(1'b1, 1'b1);
      wait_done("both_a", 40);
      check_frame("both_a");
      t_done = cyc;
      expect_frame(1'b0, 1'b0);
      n = 0;
      while (!tx_valid && n < 60) begin
         nclk();
         n++;
      end
      check("both_hdr_delay", cyc - t_done, G + 2);
      wait_done("both_s", 40);
      check_frame("both_s");
      repeat (G + 2) nclk();

      // Random data, random stalls, mid-frame input changes.
      ready_mode = 1;
      for (int f = 0; f < 6; f++) begin
         set_fields(8'($urandom), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59)),
                    5'($urandom_range(0, 23)), 5'($urandom_range(1, 31)), 4'($urandom_range(1, 12)));
         dnum_in    = 1'($urandom);
         bd_rate_in = 2'($urandom);
         old_bd     = bd_rate_in;
         al         = 1'($urandom);
         expect_frame(al, dnum_in);
         req(!al, al);
         n = 0;
         while (acc_q.size() < 2 && n < 100) begin
            nclk();
            n++;
         end
         bd_rate_in = ~old_bd;
         adc        = ~adc;
         wait_done($sformatf("rnd%0d", f), 200);
         check_frame($sformatf("rnd%0d", f));
         check("rnd_bd_hold", {30'd0, bd_rate}, {30'd0, old_bd});
         repeat (G + 2) nclk();
      end
      ready_mode = 0;
      dnum_in = 1'b0;

      // Overrun: frame held in SEND while extra sample requests arrive.
      ready_mode = 2;
      expect_frame(1'b0, 1'b0);
      req(1'b1, 1'b0);
      repeat (4) nclk();
      req(1'b1, 1'b0);
      nclk();
      check("ovr_pend_only", {31'd0, overrun}, 32'd0);
      req(1'b1, 1'b0);
      nclk();
      check("ovr_set", {31'd0, overrun}, 32'd1);
      pulse_clr();
      nclk();
      check("ovr_clr", {31'd0, overrun}, 32'd0);
      @(posedge clk);
      #1 sample_req = 1'b1; ovr_clr = 1'b1;
      @(posedge clk);
      #1 sample_req = 1'b0; ovr_clr = 1'b0;
      nclk();
      check("ovr_clr_vs_evt", {31'd0, overrun}, 32'd1);
      pulse_clr();
      nclk();
      check("ovr_clr2", {31'd0, overrun}, 32'd0);
      ready_mode = 0;
      wait_done("ovr1", 60);
      check_frame("ovr1");
      expect_frame(1'b0, 1'b0);
      wait_done("ovr2", 60);
      check_frame("ovr2");
      d0 = n_done;
      repeat (3 * G) nclk();
      check("ovr_no_third", n_done - d0, 32'd0);
      check("ovr_idle", {31'd0, busy}, 32'd0);

      // Reset during byte 4 with pending alarm, pending sample and overrun set.
      bd_rate_in = 2'd3; par_in = 2'd1;
      ready_mode = 2;
      req(1'b1, 1'b0);
      req(1'b0, 1'b1);
      req(1'b1, 1'b0);
      req(1'b1, 1'b0);
      nclk();
      check("pre_rst_ovr", {31'd0, overrun}, 32'd1);
      ready_mode = 0;
      n = 0;
      while (acc_q.size() < 4 && n < 40) begin
         nclk();
         n++;
      end
      check("pre_rst_bytes", acc_q.size(), 32'd4);
      rst = 1'b1;
      #1;
      check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, frame_done}, 32'd0);
      check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
      check("mid_rst_cfg", {26'd0, bd_rate, dnum, snum, par}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      acc_q.delete();
      repeat (2 * G + 20) nclk();
      check("post_rst_no_pend", {31'd0, busy}, 32'd0);
      check("post_rst_no_bytes", acc_q.size(), 32'd0);
      set_fields(8'h3C, 6'd59, 6'd0, 5'd23, 5'd31, 4'd12);
      expect_frame(1'b0, 1'b0);
      req(1'b1, 1'b0);
      wait_done("post_rst", 40);
      check_frame("post_rst");
      check("post_rst_bd", {30'd0, bd_rate}, 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/telemetry_frame_scheduler.md
# telemetry_frame_scheduler

Sequences the serial transmit path: collects periodic sample requests and alarm requests, arbitrates between them, and feeds one 8-byte telemetry frame at a time into the UART transmitter over a valid/ready byte handshake. Each frame carries a coherent snapshot of the ADC temperature byte and the RTC time fields. The block also owns the transmitter line configuration: baud rate, data bits, stop bits and parity. That configuration is latched only at frame boundaries, so a software change never corrupts a frame in flight. It sits between the RTC/ADC sources and the TX serializer of the pipe_line transmit side.

## Interface
- GAP_CYCLES, 16: idle cycles enforced after the last byte of a frame (≥1).
- HDR_NORM, 8'hA5: header byte of a sample frame.
- HDR_ALARM, 8'h5A: header byte of an alarm frame.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_req  in  1  one-cycle pulse; request a sample frame.
- alarm_req  in  1  one-cycle pulse; request an alarm frame.
- adc  in  8  temperature sample.
- seconds, minutes  in  6 each  RTC fields.
- hours, days  in  5 each  RTC fields.
- months  in  4  RTC field.
- bd_rate_in  in  2  requested baud select.
- dnum_in  in  1  requested data bits: 0 = 8 bits, 1 = 7 bits.
- snum_in  in  1  requested stop bits: 0 = 1 stop bit, 1 = 2 stop bits.
- par_in  in  2  requested parity mode.
- bd_rate, dnum, snum, par  out  2/1/1/2  latched configuration driven to the TX serializer.
- tx_data  out  8  byte presented to the serializer.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  serializer accepts the byte this cycle.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted.
- overrun  out  1  sticky; a sample request was dropped.
- ovr_clr  in  1  clears overrun.

## Operation
- Pending flags:
  - sample_req sets sample_pend; alarm_req sets alarm_pend.
  - A sample_req that arrives while sample_pend is already 1 sets overrun. The request is dropped.
  - A repeated alarm_req merges silently into the existing alarm_pend.
  - If ovr_clr and a new overrun event occur in the same cycle, overrun ends at 1.
- States: IDLE, LOAD, SEND, GAP.
- IDLE → LOAD when either pending flag is set.
  - Arbitration is fixed priority: alarm before sample.
  - The granted flag clears on this transition.
- LOAD, one cycle:
  - Snapshot adc and the time fields.
  - Latch bd_rate/dnum/snum/par from the *_in inputs.
  - Set byte index to 0.
  - Present the header byte with tx_valid = 1.
- SEND: byte order is header, adc, seconds, minutes, hours, days, months, checksum.
  - RTC fields are zero-extended to 8 bits.
  - Each accepted byte (tx_valid && tx_ready at a rising edge) advances the index. The next byte is presented in the following cycle, so back-to-back transfers are allowed.
  - While tx_ready is low, tx_data and tx_valid hold stable.
- Checksum: XOR of bytes 1..6.
- 7-bit mode (latched dnum = 1): every byte, including the header, is ANDed with 8'h7F before transmission. The checksum is computed over the masked bytes.
- On acceptance of the checksum byte:
  - tx_valid drops.
  - frame_done pulses for one cycle.
  - The state moves to GAP.
- GAP counts GAP_CYCLES cycles, then moves to IDLE.
- Requests arriving during LOAD, SEND or GAP only set their pending flags.
- The configuration outputs change only in LOAD.

## Timing
- Reset values:
  - bd_rate = 0, dnum = 0, snum = 0, par = 0.
  - tx_data = 0, tx_valid = 0, busy = 0, frame_done = 0, overrun = 0.
  - Both pending flags = 0, state = IDLE.
- Reset asserted mid-frame: the frame is abandoned immediately and the outputs go to their reset values. No partial frame resumes.
- Latency: a request sampled at edge k gives state LOAD after edge k. tx_valid is high and the header is presented after edge k+1.
- Minimum frame length, with tx_ready held at 1: 8 accept cycles.
- sample_req and alarm_req in the same cycle: the alarm frame goes first. The sample frame starts GAP_CYCLES+1 cycles after that frame_done.
- Requests during GAP are not served before GAP expires.

## Structure
- Shared package frame_pkg holds:
  - the state encoding;
  - byte-index constants 0..7 and FRAME_LEN = 8;
  - default header constants;
  - the 7-bit mask constant.
- Sub-module frame_req_arbiter holds the pending flags, the priority grant and overrun/ovr_clr handling. The top level holds the FSM, the snapshot and configuration registers, the checksum and the gap counter.

## Test plan
- Sample frame, 8-bit mode:
  - Stimulus: adc = 8'h8F, sec = 5, min = 10, hr = 3, day = 12, mon = 2, tx_ready = 1, one sample_req.
  - Required bytes: A5 8F 05 0A 03 0C 02 8D.
  - frame_done pulses once; busy is high through GAP.
- Same values in 7-bit mode (dnum_in = 1) -> 25 0F 05 0A 03 0C 02 0D.
- sample_req and alarm_req in the same cycle:
  - The alarm frame (header 5A) completes first.
  - The sample frame (header A5) starts exactly GAP_CYCLES+1 cycles after the first frame_done.
- Random tx_ready stalls (low 0–5 cycles):
  - tx_data is stable while stalled; no byte is duplicated or skipped.
  - bd_rate_in changed mid-frame does not change bd_rate until the next LOAD.
- Overrun:
  - Two sample_req pulses while a frame is in SEND and sample_pend is already set -> overrun = 1. Only one further sample frame is sent.
  - ovr_clr -> overrun = 0.
- rst pulsed during byte 4:
  - All outputs return to reset values asynchronously and pending flags clear.
  - A new sample_req after reset produces a complete, correct frame.
